// File: rtl/fractal_pkg.sv
// Shared definitions for the fractal stream buffer: controller state
// encoding and the layout of a packed buffer word.
package fractal_pkg;

    // Controller states: PASS forwards pixels, DROP discards until the next frame start.
    typedef enum logic {
        ST_PASS = 1'b0,
        ST_DROP = 1'b1
    } state_e;

    // Sideband bits stored above the pixel data in each buffer word.
    localparam int unsigned SIDEBAND_BITS = 2;

    // Pixel data always sits at the bottom of the word.
    localparam int unsigned DATA_LSB = 0;

    // Word layout is {line_end, frame_start, data}.
    function automatic int unsigned frame_start_bit(input int unsigned data_width);
        return data_width;
    endfunction

    function automatic int unsigned line_end_bit(input int unsigned data_width);
        return data_width + 1;
    endfunction

    function automatic int unsigned word_width(input int unsigned data_width);
        return data_width + SIDEBAND_BITS;
    endfunction

endpackage

// File: rtl/fractal_sync_fifo.sv
// Single-clock first-word-fall-through FIFO: storage array, wrapping
// read/write pointers and an occupancy count. Head word is presented
// combinationally whenever the FIFO is non-empty and reads as zero when empty.
module fractal_sync_fifo
    import fractal_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int WIDTH = 26,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             valid,
    output logic             full,
    output logic [LW-1:0]    level
);

    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [LW-1:0] LVL_ONE = 1;
    localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level_q;
    logic             do_wr;
    logic             do_rd;

    assign valid   = (level_q != '0);
    assign full    = (level_q == LVL_MAX);
    assign level   = level_q;
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && valid;
    assign rd_data = valid ? mem[rd_ptr] : '0;

    // Storage array write; contents need no reset because level gates the output.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); level tracks net push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_wr, do_rd})
                2'b10:   level_q <= level_q + LVL_ONE;
                2'b01:   level_q <= level_q - LVL_ONE;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/fractal_stream_buffer.sv
// Pixel stream buffer: accepts a non-throttled pixel stream, buffers it in a
// FWFT FIFO and emits it as an AXI-Stream video master. On overflow the rest
// of the frame is dropped and buffering resumes at the next frame start.
//
// Handshake: a beat transfers on every rising aclk edge where m_axis_tvalid
// and m_axis_tready are both high; while tvalid is high and tready low the
// tdata/tuser/tlast values hold. The upstream side has no ready: a pixel with
// data_enable_in high is either accepted that edge or discarded.
module fractal_stream_buffer
    import fractal_pkg::*;
#(
    parameter int DEPTH      = 64,
    parameter int DATA_WIDTH = 24
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    frame_start_in,
    input  logic                    line_end_in,
    input  logic                    data_enable_in,
    output logic                    m_axis_tvalid,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic                    m_axis_tuser,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready,
    output logic                    overflow,
    input  logic                    overflow_clear,
    output logic [$clog2(DEPTH):0]  level,
    output state_e                  dbg_state
);

    localparam int WW     = word_width(DATA_WIDTH);
    localparam int FS_BIT = frame_start_bit(DATA_WIDTH);
    localparam int LE_BIT = line_end_bit(DATA_WIDTH);

    state_e          state_q;
    state_e          state_d;
    logic            accept;
    logic            drop_event;
    logic            pop;
    logic            fifo_full;
    logic [WW-1:0]   wr_word;
    logic [WW-1:0]   rd_word;

    assign wr_word   = {line_end_in, frame_start_in, data_in};
    assign pop       = m_axis_tvalid && m_axis_tready;
    assign dbg_state = state_q;

    assign m_axis_tdata = rd_word[DATA_LSB +: DATA_WIDTH];
    assign m_axis_tuser = rd_word[FS_BIT];
    assign m_axis_tlast = rd_word[LE_BIT];

    fractal_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WW)
    ) u_fifo (
        .clk     (aclk),
        .rst_n   (aresetn),
        .wr_en   (accept),
        .wr_data (wr_word),
        .rd_en   (pop),
        .rd_data (rd_word),
        .valid   (m_axis_tvalid),
        .full    (fifo_full),
        .level   (level)
    );

    // Drop controller state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_PASS;
        end else begin
            state_q <= state_d;
        end
    end

    // Accept/drop decision; fullness is judged before any same-edge pop.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        drop_event = 1'b0;
        case (state_q)
            ST_PASS: begin
                if (data_enable_in) begin
                    if (!fifo_full) begin
                        accept = 1'b1;
                    end else begin
                        drop_event = 1'b1;
                        state_d    = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                if (data_enable_in && frame_start_in && !fifo_full) begin
                    accept  = 1'b1;
                    state_d = ST_PASS;
                end
            end
            default: state_d = ST_PASS;
        endcase
    end

    // Sticky overflow flag; a new drop outranks a simultaneous clear.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            overflow <= 1'b0;
        end else if (drop_event) begin
            overflow <= 1'b1;
        end else if (overflow_clear) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fractal_stream_buffer.sv
module tb_fractal_stream_buffer;
  import fractal_pkg::*;

  localparam int DEPTH = 64;
  localparam int DW    = 24;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          aclk;
  logic          aresetn;
  logic [DW-1:0] data_in;
  logic          frame_start_in;
  logic          line_end_in;
  logic          data_enable_in;
  logic          m_axis_tvalid;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tuser;
  logic          m_axis_tlast;
  logic          m_axis_tready;
  logic          overflow;
  logic          overflow_clear;
  logic [LW-1:0] level;
  state_e        dbg_state;

  int checks = 0;
  int errors = 0;
  int beats  = 0;
  logic [DW+1:0] exp_q[$];

  fractal_stream_buffer #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .data_in        (data_in),
    .frame_start_in (frame_start_in),
    .line_end_in    (line_end_in),
    .data_enable_in (data_enable_in),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tuser   (m_axis_tuser),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tready  (m_axis_tready),
    .overflow       (overflow),
    .overflow_clear (overflow_clear),
    .level          (level),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // one clock of upstream stimulus; returns 1 ns after the edge
  task automatic drive(input logic de, input logic fs, input logic le,
                       input logic [DW-1:0] d, input logic rdy, input logic push);
    data_enable_in = de;
    frame_start_in = fs;
    line_end_in    = le;
    data_in        = d;
    m_axis_tready  = rdy;
    if (push) exp_q.push_back({le, fs, d});
    @(posedge aclk);
    #1;
    data_enable_in = 1'b0;
    frame_start_in = 1'b0;
    line_end_in    = 1'b0;
    overflow_clear = 1'b0;
  endtask

  task automatic drain(input string name);
    bit done = 0;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      if (exp_q.size() == 0 && level == 0) done = 1;
      else begin
        @(posedge aclk);
        #1;
      end
    end
    chk(name, {31'd0, done}, 32'd1);
  endtask

  // scoreboard: every beat must match the head of the expected queue
  always @(negedge aclk) begin
    if (aresetn && m_axis_tvalid && m_axis_tready) begin
      checks++;
      beats++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got 0x%0h expected none", {m_axis_tlast, m_axis_tuser, m_axis_tdata});
      end else begin
        logic [DW+1:0] e;
        e = exp_q.pop_front();
        if ({m_axis_tlast, m_axis_tuser, m_axis_tdata} !== e) begin
          errors++;
          $display("FAIL beat_data: got 0x%0h expected 0x%0h", {m_axis_tlast, m_axis_tuser, m_axis_tdata}, e);
        end
      end
    end
  end

  typedef struct {
    logic          de;
    logic          fs;
    logic          le;
    logic [DW-1:0] data;
    logic          rdy;
    logic          push;
    int            exp_level;
    logic          exp_tvalid;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int b0;
    aresetn        = 1'b0;
    data_in        = '0;
    frame_start_in = 1'b0;
    line_end_in    = 1'b0;
    data_enable_in = 1'b0;
    m_axis_tready  = 1'b0;
    overflow_clear = 1'b0;

    // reset state
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_tvalid", {31'd0, m_axis_tvalid}, 0);
    chk("rst_tdata", {8'd0, m_axis_tdata}, 0);
    chk("rst_tuser", {31'd0, m_axis_tuser}, 0);
    chk("rst_tlast", {31'd0, m_axis_tlast}, 0);
    chk("rst_overflow", {31'd0, overflow}, 0);
    chk("rst_level", {25'd0, level}, 0);
    chk("rst_state", {31'd0, dbg_state}, ST_PASS);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // latency: single word into an empty buffer is visible after one edge
    drive(1, 1, 0, 24'hABCDEF, 0, 1);
    chk("lat_tvalid", {31'd0, m_axis_tvalid}, 1);
    chk("lat_tdata", {8'd0, m_axis_tdata}, 32'hABCDEF);
    chk("lat_tuser", {31'd0, m_axis_tuser}, 1);
    drive(0, 0, 0, 0, 0, 0);
    chk("lat_hold", {8'd0, m_axis_tdata}, 32'hABCDEF);
    drain("lat_drain");

    // table-driven cycles: push, pop, simultaneous push+pop, empty
    tbl[0] = '{1, 1, 0, 24'h000001, 0, 1, 1, 1};
    tbl[1] = '{1, 0, 0, 24'h000002, 0, 1, 2, 1};
    tbl[2] = '{0, 0, 0, 24'h000000, 1, 0, 1, 1};
    tbl[3] = '{1, 0, 1, 24'h000003, 1, 1, 1, 1};
    tbl[4] = '{0, 0, 0, 24'h000000, 1, 0, 0, 0};
    tbl[5] = '{0, 0, 0, 24'h000000, 0, 0, 0, 0};
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].de, tbl[i].fs, tbl[i].le, tbl[i].data, tbl[i].rdy, tbl[i].push);
      chk($sformatf("tbl%0d_level", i), {25'd0, level}, tbl[i].exp_level);
      chk($sformatf("tbl%0d_tvalid", i), {31'd0, m_axis_tvalid}, {31'd0, tbl[i].exp_tvalid});
    end

    // passthrough: 1920 pixels, sink always ready
    b0 = beats;
    for (int i = 0; i < 1920; i++) begin
      drive(1, i == 0, i == 1919, DW'(i * 7919), 1, 1);
      if (level > 1) chk($sformatf("pass_level_%0d", i), {25'd0, level}, 1);
    end
    drain("pass_drain");
    chk("pass_beats", beats - b0, 1920);

    // stall: fill to capacity, then one more pixel overflows
    for (int i = 0; i < 64; i++) drive(1, i == 0, 0, DW'(24'h500000 + i), 0, 1);
    chk("stall_level", {25'd0, level}, 64);
    chk("stall_ovf0", {31'd0, overflow}, 0);
    drive(1, 0, 0, 24'hDEAD01, 0, 0);
    chk("stall_ovf1", {31'd0, overflow}, 1);
    chk("stall_level_kept", {25'd0, level}, 64);
    chk("stall_state", {31'd0, dbg_state}, ST_DROP);
    drive(1, 1, 0, 24'hDEAD02, 0, 0);
    chk("drop_fs_full_level", {25'd0, level}, 64);
    chk("drop_fs_full_state", {31'd0, dbg_state}, ST_DROP);

    // resync: rest of frame is discarded, next frame start resumes
    for (int i = 0; i < 20; i++) drive(1, 0, (i % 5) == 4, DW'(24'hBAD000 + i), 1, 0);
    chk("resync_level", {25'd0, level}, 44);
    drive(1, 1, 0, 24'h777777, 1, 1);
    chk("resync_state", {31'd0, dbg_state}, ST_PASS);
    for (int i = 0; i < 3; i++) drive(1, 0, i == 2, DW'(24'h777780 + i), 1, 1);
    drain("resync_drain");

    // concurrency: clear, fill 10, accept+pop keeps level
    overflow_clear = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    chk("clr_ovf", {31'd0, overflow}, 0);
    for (int i = 0; i < 10; i++) drive(1, i == 0, 0, DW'(24'h0C0000 + i), 0, 1);
    chk("conc_level10", {25'd0, level}, 10);
    drive(1, 0, 0, 24'h0C00AA, 1, 1);
    chk("conc_level_same", {25'd0, level}, 10);
    for (int i = 0; i < 54; i++) drive(1, 0, 0, DW'(24'h0D0000 + i), 0, 1);
    chk("conc_full", {25'd0, level}, 64);
    overflow_clear = 1'b1;
    drive(1, 0, 0, 24'hDEAD03, 0, 0);
    chk("conc_ovf_wins", {31'd0, overflow}, 1);
    overflow_clear = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    chk("conc_clear_alone", {31'd0, overflow}, 0);
    drain("conc_drain");

    // reset: first word after release accepted without frame start
    aresetn = 1'b0;
    #2;
    aresetn = 1'b1;
    chk("rst2_state", {31'd0, dbg_state}, ST_PASS);
    @(posedge aclk);
    #1;
    for (int i = 0; i < 30; i++) drive(1, 0, 0, DW'(24'h300000 + i), 0, 1);
    chk("rst_fill_level", {25'd0, level}, 30);
    #2;
    aresetn = 1'b0;
    #1;
    chk("async_tvalid", {31'd0, m_axis_tvalid}, 0);
    chk("async_level", {25'd0, level}, 0);
    chk("async_tdata", {8'd0, m_axis_tdata}, 0);
    exp_q.delete();
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    drive(1, 0, 0, 24'h123456, 0, 1);
    chk("post_rst_tvalid", {31'd0, m_axis_tvalid}, 1);
    chk("post_rst_tdata", {8'd0, m_axis_tdata}, 32'h123456);
    chk("post_rst_level", {25'd0, level}, 1);
    drain("post_rst_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
